// File: rtl/delay_line_if.sv
// Sample/control bundle for delay_line: the driver side (master) supplies
// control and data, and the delay line (slave) returns the delayed tap.
interface delay_line_if #(
  parameter int WIDTH     = 1,
  parameter int MAX_DEPTH = 16
);
  localparam int DW = $clog2(MAX_DEPTH + 1);

  logic             en;
  logic             flush;
  logic [DW-1:0]    depth;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;

  modport master (
    output en, flush, depth, data_in,
    input  data_out, valid_out
  );

  modport slave (
    input  en, flush, depth, data_in,
    output data_out, valid_out
  );
endinterface

// File: rtl/delay_line.sv
// Enable-gated, run-time tap-selectable shift-register delay line. It has a
// synchronous flush and a fill counter that drives the valid flag.
module delay_line #(
  parameter  int WIDTH     = 1,
  parameter  int MAX_DEPTH = 16,
  localparam int DW        = $clog2(MAX_DEPTH + 1)
) (
  input  logic         clock,
  input  logic         reset,
  delay_line_if.slave  bus
);

  localparam logic [DW-1:0] MAX_D = DW'(MAX_DEPTH);

  logic [WIDTH-1:0] sr_q [MAX_DEPTH];
  logic [WIDTH-1:0] sr_d [MAX_DEPTH];
  logic [DW-1:0]    fill_q, fill_d;
  logic [DW-1:0]    d_eff;
  logic [WIDTH-1:0] tap;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    sr_d   = sr_q;
    fill_d = fill_q;
    if (bus.flush) begin
      for (int i = 0; i < MAX_DEPTH; i++) sr_d[i] = '0;
      fill_d = '0;
    end else if (bus.en) begin
      sr_d[0] = bus.data_in;
      for (int i = 1; i < MAX_DEPTH; i++) sr_d[i] = sr_q[i-1];
      if (fill_q != MAX_D) fill_d = fill_q + DW'(1);
    end
  end

  // NOTE: the stages are plain flops, not RAM. They are reset because data_out must read 0 after reset.
  // NOTE: sequential state uses non-blocking assignment, so all stages see pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MAX_DEPTH; i++) sr_q[i] <= '0;
      fill_q <= '0;
    end else begin
      sr_q   <= sr_d;
      fill_q <= fill_d;
    end
  end

  assign d_eff = (bus.depth > MAX_D) ? MAX_D : bus.depth;

  // Tap d reads stage d-1. Depth 0 is a combinational bypass of data_in.
  always_comb begin
    tap = bus.data_in;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (d_eff == DW'(i + 1)) tap = sr_q[i];
    end
  end

  assign bus.data_out  = tap;
  assign bus.valid_out = (fill_q >= d_eff);

endmodule

// File: tb/tb_delay_line.sv
// Scoreboard bench for delay_line (WIDTH=8, MAX_DEPTH=16): the driver queues
// a hand-derived expected output each cycle, and a monitor checks it mid-cycle.
module tb_delay_line;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  delay_line_if #(.WIDTH(8), .MAX_DEPTH(16)) bus ();

  delay_line #(.WIDTH(8), .MAX_DEPTH(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string      name;
    logic [7:0] d;
    logic       v;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  // One cycle: apply inputs just after the edge and queue what the outputs must show before the next edge.
  task automatic step(input logic rst, input logic e, input logic fl, input logic [4:0] dep,
                      input logic [7:0] din, input logic [7:0] eo, input logic ev, input string name);
    exp_t x;
    @(posedge clock);
    #1;
    reset       = rst;
    bus.en      = e;
    bus.flush   = fl;
    bus.depth   = dep;
    bus.data_in = din;
    x.name = name;
    x.d    = eo;
    x.v    = ev;
    q.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        x = q.pop_front();
        check({x.name, ".data"},  bus.data_out, x.d);
        check({x.name, ".valid"}, {7'd0, bus.valid_out}, {7'd0, x.v});
      end
    end
  end

  initial begin : driver
    bus.en = 1'b1; bus.flush = 1'b0; bus.depth = 5'd16; bus.data_in = 8'h00;

    // Reset held low: outputs are 0/0 at depth 16. At depth 0 they bypass and show valid.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 16, 8'h00, 8'h00, 0, "rst_hold");
    step(0, 1, 0, 0, 8'h42, 8'h42, 1, "rst_bypass");

    // Legacy depth-16 pulse: step j follows j edges, and the pulse appears only at j=16.
    for (int j = 0; j < 20; j++)
      step(1, 1, 0, 16, (j == 0) ? 8'h01 : 8'h00, (j == 16) ? 8'h01 : 8'h00, j >= 16, "legacy");

    // Flush with en=1: the line still reads 0 at tap 3 and fill=16 before the edge.
    step(1, 1, 1, 3, 8'hFF, 8'h00, 1, "flush0");

    // Ramp at depth 3: step k shows k-2 once k>=3.
    for (int k = 0; k < 10; k++)
      step(1, 1, 0, 3, 8'(k + 1), (k >= 3) ? 8'(k - 2) : 8'h00, k >= 3, "ramp3");
    // Grow to depth 5 mid-stream: the sample captured 5 advances back is shown immediately.
    step(1, 1, 0, 5, 8'd11, 8'd6, 1, "grow5a");
    step(1, 1, 0, 5, 8'd12, 8'd7, 1, "grow5b");

    // Flush with en=1 and data 0xFF: pre-edge tap 5 shows 8. After the edge the 0xFF is gone.
    step(1, 1, 1, 5, 8'hFF, 8'd8, 1, "flush1");
    for (int m = 0; m < 8; m++)
      step(1, 1, 0, 5, 8'(8'h10 + m), (m >= 5) ? 8'(8'h10 + m - 5) : 8'h00, m >= 5, "postflush");

    // Enable gaps at depth 4. The flush is applied with en=0, and pre-edge tap 4 shows 0x14.
    step(1, 0, 1, 4, 8'h00, 8'h14, 1, "flush2");
    step(1, 1, 0, 4, 8'h0A, 8'h00, 0, "gap0");
    step(1, 0, 0, 4, 8'h55, 8'h00, 0, "gap1");
    step(1, 0, 0, 4, 8'h66, 8'h00, 0, "gap2");
    step(1, 1, 0, 4, 8'h0B, 8'h00, 0, "gap3");
    step(1, 1, 0, 4, 8'h0C, 8'h00, 0, "gap4");
    step(1, 1, 0, 4, 8'h0D, 8'h00, 0, "gap5");
    step(1, 1, 0, 4, 8'h0E, 8'h0A, 1, "gap6");
    step(1, 0, 0, 4, 8'h77, 8'h0B, 1, "gap7");
    step(1, 0, 0, 4, 8'h88, 8'h0B, 1, "gap8");

    // fill=5 here. Depth 6 exceeds it, and depth 5 exposes the older sample 0x0A.
    step(1, 0, 0, 6, 8'h00, 8'h00, 0, "grow6");
    step(1, 0, 0, 5, 8'h00, 8'h0A, 1, "shrink5");

    // Bypass at depth 0.
    step(1, 0, 0, 0, 8'h3C, 8'h3C, 1, "bypass_a");
    step(1, 0, 0, 0, 8'hC3, 8'hC3, 1, "bypass_b");

    // Clamp: depth 20 behaves as depth 16.
    step(1, 0, 1, 20, 8'h00, 8'h00, 0, "flush3");
    for (int k = 0; k < 19; k++)
      step(1, 1, 0, 20, 8'(k + 1), (k >= 16) ? 8'(k - 15) : 8'h00, k >= 16, "clamp20");

    // Async reset between edges with the line full: outputs clear before any edge.
    step(0, 1, 0, 20, 8'h99, 8'h00, 0, "async_rst");
    for (int d = 1; d <= 16; d++)
      step(1, 0, 0, 5'(d), 8'h5A, 8'h00, 0, "post_rst_stage");

    begin : drain
      int n = 0;
      while (q.size() > 0 && n < 10) begin
        @(negedge clock);
        n++;
      end
      @(posedge clock);
      if (q.size() > 0) begin
        bad++;
        total++;
        $display("FAIL drain: pending=%0d want=0", q.size());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
